bitwise_logic_pipe: RTL and testbench
=====================================

// Module: bitwise_logic_pipe
// PURPOSE
//  Parametrised, registered successor to the fixed 16-bit bitwise gate arrays.
//  - Applies one of eight bitwise ops to two WIDTH-bit operands.
//  - Uses a valid/ready handshake on both sides.
//  - Registers the result behind a 2-entry skid buffer: full throughput, registered in_ready.
//  - Sits between operand sources (register file, ALU front end) and any stalling consumer.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; legal range >= 1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset: asynchronous assert, active-low
//  in_valid   in   1      a, b, op are valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  op         in   3      op select (see BEHAVIOUR)
//  out_valid  out  1      out (and flags) valid
//  out_ready  in   1      consumer accepts out this cycle
//  out        out  WIDTH  result
//  zr         out  1      result == 0 (only when BITWISE_FLAGS_EN is defined)
//  ng         out  1      result[WIDTH-1] (only when BITWISE_FLAGS_EN is defined)
// BEHAVIOUR
//  - op encoding:
//    - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a, 111 pass a.
//    - b is ignored for 110 and 111.
//  - Transfer events:
//    - in_fire  = in_valid & in_ready.
//    - out_fire = out_valid & out_ready.
//  - Storage: main register M drives out; skid register S.
//  - State machine (state encodes occupancy):
//    - EMPTY: out_valid=0, in_ready=1.
//      - in_fire -> M<=f(a,b,op), go HOLD.
//    - HOLD: out_valid=1, in_ready=1.
//      - in_fire & out_fire -> M<=new, stay HOLD.
//      - in_fire & !out_fire -> S<=new, go SKID.
//      - !in_fire & out_fire -> go EMPTY.
//      - otherwise stay HOLD.
//    - SKID: out_valid=1, in_ready=0.
//      - out_fire -> M<=S, go HOLD.
//      - inputs are ignored while in_ready=0.
//  - Timing:
//    - in_ready and out_valid are decoded from state only; no combinational path from out_ready.
//    - Latency: result visible on out exactly 1 cycle after in_fire (EMPTY or HOLD case).
//    - Throughput: 1 result/cycle while out_ready=1.
//  - Ordering: results leave in acceptance order; none dropped or duplicated.
//  - Stability: while out_valid=1 and out_ready=0, out, zr and ng hold stable.
//  - Idle values: M and S are written only on an accepted transfer; out retains its last value
//    when EMPTY. Downstream logic must qualify out with out_valid.
//  - Reset (rst_n=0, async, any time incl. mid-transfer):
//    - state=EMPTY, out_valid=0, in_ready=1, M=0, S=0, zr=0, ng=0.
//    - In-flight data is discarded.
//    - First accept possible on the first clk edge after rst_n deasserts.
//  - WIDTH=1: ng equals out[0]; all ops still apply.
// CONFIGURATION
//  - BITWISE_FLAGS_EN defined:
//    - zr and ng are computed from f(a,b,op) at accept.
//    - They are stored alongside M and S (WIDTH+2 bits per entry) and obey the same
//      stability rules.
//  - BITWISE_FLAGS_EN undefined: zr and ng ports and their storage are absent.
// TESTING
//  - Reset: rst_n=0 mid-SKID -> out_valid=0, in_ready=1, out=0 asynchronously. Then a=16'h00FF,
//    b=16'h0F0F, op=000 -> out=16'h000F one cycle later.
//  - Op sweep: a=16'hAAAA, b=16'hCCCC, ops 000..111, out_ready=1 -> 8888, EEEE, 6666, 7777,
//    1111, 9999, 5555, AAAA on consecutive cycles.
//  - Backpressure: out_ready=0, push 2 items -> in_ready=0 after the 2nd; out stays item 1.
//    Raise out_ready -> items 1, 2 in order, in_ready=1.
//  - Streaming: 100 random vectors, random out_ready (50%) -> scoreboard exact match, no
//    loss/duplication, out stable while stalled.
//  - Flags (BITWISE_FLAGS_EN): a=16'hFFFF, b=16'hFFFF, op=010 -> out=0, zr=1, ng=0.
//    op=000 -> zr=0, ng=1.
//  - WIDTH=1 build: a=1, b=0, ops 000..111 -> 0, 1, 1, 1, 0, 0, 0, 1.

Source files
------------

// File: rtl/bitwise_logic_pipe.sv
// Bitwise op unit (AND/OR/XOR/NAND/NOR/XNOR/NOT a/pass a) with a registered 2-entry skid output.
// Define BITWISE_FLAGS_EN to add zr/ng result flags stored alongside each entry.
module bitwise_logic_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_o
`ifdef BITWISE_FLAGS_EN
    ,
    output logic             zr_o,
    output logic             ng_o
`endif
);

`ifdef BITWISE_FLAGS_EN
    localparam int EW = WIDTH + 2;  // {zr, ng, result}
`else
    localparam int EW = WIDTH;
`endif

    typedef enum logic [1:0] {EMPTY, HOLD, SKID} state_e;

    state_e           state_q, state_d;
    logic [EW-1:0]    m_q, m_d, s_q, s_d;
    logic [EW-1:0]    new_entry;
    logic [WIDTH-1:0] res;
    logic             in_fire, out_fire;

    always_comb begin
        case (op_i)
            3'b000:  res = a_i & b_i;
            3'b001:  res = a_i | b_i;
            3'b010:  res = a_i ^ b_i;
            3'b011:  res = ~(a_i & b_i);
            3'b100:  res = ~(a_i | b_i);
            3'b101:  res = ~(a_i ^ b_i);
            3'b110:  res = ~a_i;
            default: res = a_i;
        endcase
    end

`ifdef BITWISE_FLAGS_EN
    assign new_entry = {(res == '0), res[WIDTH-1], res};
    assign zr_o      = m_q[WIDTH+1];
    assign ng_o      = m_q[WIDTH];
`else
    assign new_entry = res;
`endif

    // Handshake outputs come from state alone, so out_ready never reaches in_ready.
    assign in_ready_o  = (state_q != SKID);
    assign out_valid_o = (state_q != EMPTY);
    assign out_o       = m_q[WIDTH-1:0];
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    m_d     = new_entry;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (in_fire && out_fire) begin
                    m_d = new_entry;
                end else if (in_fire) begin
                    s_d     = new_entry;
                    state_d = SKID;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                if (out_fire) begin
                    m_d     = s_q;
                    state_d = HOLD;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Bench for bitwise_logic_pipe: queue model with per-cycle compare, directed vectors, random stream,
// and a WIDTH=1 instance.
module tb_bitwise_logic_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [15:0] a, b;
    logic [2:0]  op;
    logic        in_ready, out_valid;
    logic [15:0] out;

    logic        in_valid1, out_ready1;
    logic        a1, b1;
    logic [2:0]  op1;
    logic        in_ready1, out_valid1;
    logic        out1;

`ifdef BITWISE_FLAGS_EN
    logic        zr, ng, zr1, ng1;
`endif

    int checks = 0;
    int errors = 0;
    int pushes = 0;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .op_i(op),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_o(out)
`ifdef BITWISE_FLAGS_EN
        , .zr_o(zr), .ng_o(ng)
`endif
    );

    bitwise_logic_pipe #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .a_i(a1), .b_i(b1), .op_i(op1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready1), .out_o(out1)
`ifdef BITWISE_FLAGS_EN
        , .zr_o(zr1), .ng_o(ng1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_f(input logic [15:0] x, input logic [15:0] y,
                                            input logic [2:0] o);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // Occupancy model: a FIFO of at most two results in acceptance order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                q.push_back(model_f(a, b, op));
                pushes++;
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (out_valid && q.size() != 0) begin
            chk("out", {16'd0, out}, {16'd0, q[0]});
`ifdef BITWISE_FLAGS_EN
            chk("zr", {31'd0, zr}, {31'd0, q[0] == 16'd0});
            chk("ng", {31'd0, ng}, {31'd0, q[0][15]});
`endif
        end
    end

    logic [15:0] exp_sweep [8];
    logic        exp_w1 [8];

    initial begin
        int last, cyc;
        exp_sweep = '{16'h8888, 16'hEEEE, 16'h6666, 16'h7777,
                      16'h1111, 16'h9999, 16'h5555, 16'hAAAA};
        exp_w1    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = 1'b0; b1 = 1'b0; op1 = '0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out", {16'd0, out}, 32'd0);
`ifdef BITWISE_FLAGS_EN
        chk("rst_zr", {31'd0, zr}, 32'd0);
        chk("rst_ng", {31'd0, ng}, 32'd0);
`endif
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

        // Op sweep, one result per cycle.
        out_ready = 1'b1; a = 16'hAAAA; b = 16'hCCCC;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #2;
            if (k > 0) chk("sweep", {16'd0, out}, {16'd0, exp_sweep[k-1]});
            in_valid = 1'b1; op = 3'(k);
        end
        @(posedge clk); #2;
        chk("sweep", {16'd0, out}, {16'd0, exp_sweep[7]});
        in_valid = 1'b0;
        @(posedge clk); #2;

        // Backpressure: two items fill M and S.
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h0; op = 3'd7;
        @(posedge clk); #2;
        chk("bp_out1", {16'd0, out}, 32'h1234);
        chk("bp_ready1", {31'd0, in_ready}, 32'd1);
        a = 16'h5678;
        @(posedge clk); #2;
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_out_hold", {16'd0, out}, 32'h1234);
        in_valid = 1'b0;
        @(posedge clk); #2;
        chk("bp_out_stall", {16'd0, out}, 32'h1234);
        out_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_out2", {16'd0, out}, 32'h5678);
        chk("bp_ready2", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #2;
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset asserted mid-SKID.
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h0F00; op = 3'd7;
        @(posedge clk); #2 a = 16'h00F0;
        @(posedge clk); #2 in_valid = 1'b0;
        chk("skid_reached", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_out", {16'd0, out}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; a = 16'h00FF; b = 16'h0F0F; op = 3'd0;
        @(posedge clk); #2;
        in_valid = 1'b0;
        chk("post_rst_out", {16'd0, out}, 32'h000F);

`ifdef BITWISE_FLAGS_EN
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; op = 3'd2;
        @(posedge clk); #2;
        chk("flag_xor_out", {16'd0, out}, 32'd0);
        chk("flag_xor_zr", {31'd0, zr}, 32'd1);
        chk("flag_xor_ng", {31'd0, ng}, 32'd0);
        op = 3'd0;
        @(posedge clk); #2;
        in_valid = 1'b0;
        chk("flag_and_zr", {31'd0, zr}, 32'd0);
        chk("flag_and_ng", {31'd0, ng}, 32'd1);
`endif

        // Random stream with 50% backpressure.
        last = pushes;
        in_valid = 1'b0;
        cyc = 0;
        while (pushes < last + 100 && cyc < 2000) begin
            @(posedge clk); #2;
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid || pushes != last) begin
                last = (pushes != last) ? pushes : last;
                in_valid = ($urandom_range(0, 3) != 0);
                a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
            end
            if (pushes >= last + 100) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 100) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk("stream_drain", q.size(), 32'd0);

        // WIDTH=1 instance.
        a1 = 1'b1; b1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #2;
            if (k > 0) chk("w1_sweep", {31'd0, out1}, {31'd0, exp_w1[k-1]});
            in_valid1 = 1'b1; op1 = 3'(k);
        end
        @(posedge clk); #2;
        chk("w1_sweep", {31'd0, out1}, {31'd0, exp_w1[7]});
`ifdef BITWISE_FLAGS_EN
        chk("w1_ng", {31'd0, ng1}, {31'd0, out1});
`endif
        in_valid1 = 1'b0;
        @(posedge clk); #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
